rv32m_muldiv: RTL and testbench
===============================

Name: rv32m_muldiv

Overview:
RV32M multiply/divide unit inside the execute stage. It accepts rs1/rs2 operands and funct3, then computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. Multiplies take multiple cycles; divides iterate one quotient bit per cycle. The execute stage stalls while START=1 and READY=0.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  level request; held high by EX until the result is accepted; low = idle or flushed
- STALL_M_STD  in  1  pipeline-advance enable; in DONE with this high, the result is consumed
- M_CNT  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- RS1  in  32  rs1 operand (dividend / multiplicand)
- RS2  in  32  rs2 operand (divisor / multiplier)
- OUT  out  32  result register
- READY  out  1  result valid / no stall required

Behaviour:
- Reset (async, RST_N=0): state=IDLE, OUT=0, divider registers=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - START=0: stay in IDLE.
  - START=1: capture RS1, RS2 and M_CNT; go to MUL if M_CNT[2]=0, otherwise DIV.
- MUL (1 cycle):
  - Form the 64-bit product of 33-bit extended operands.
  - Signed×signed for MULH, signed×unsigned for MULHSU (rs1 signed), unsigned×unsigned for MULHU/MUL.
  - OUT <= low word for MUL, high word for the others; go to DONE.
- DIV (32 cycles): restoring division on magnitudes, one bit per cycle; 5-bit counter 31→0. On the last iteration, apply signs and go to DONE.
  - DIV: quotient sign = sign(rs1) XOR sign(rs2).
  - REM: remainder sign = sign(rs1).
  - DIVU/REMU: unsigned, no sign fixup.
- Special cases (exact RISC-V results):
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: DIV → 0x80000000, REM → 0.
- DONE: READY=1.
  - STALL_M_STD=1 or START=0: go to IDLE. OUT keeps its value.
- READY (combinational) = (state==DONE) | (state==IDLE & !START).
- Latency from the IDLE START edge to READY=1: multiply 2 cycles; divide 33 cycles.
- START falls in MUL or DIV (flush): abort, go to IDLE next cycle, OUT unchanged.
- Operand changes after capture are ignored.
- Back-to-back ops: after DONE→IDLE, a still-high START (next instruction) begins a new capture in IDLE.

Optional Feature:
- Macro RV32M_DIV_EARLY_EXIT_EN.
- Defined: on capture, divisor==0 or signed overflow goes straight to DONE with the special-case result loaded into OUT; latency is 1 cycle.
- Undefined: these cases run the full 32 iterations (33-cycle latency) and the fixup yields the same values.

Decomposition:
- Package rv32m_pkg:
  - funct3 localparams: F3_MUL … F3_REMU.
  - State encoding: IDLE/MUL/DIV/DONE.
  - XLEN constant.
- Natural sub-module rv32m_div_core: iterative restoring divider with start/abort/done, unsigned only.
- Top level holds the multiplier, sign handling and FSM.

Test Plan:
- MUL: RS1=7, RS2=-3, M_CNT=000, START held → READY 2 cycles later, OUT=0xFFFFFFEB; STALL_M_STD=1 returns to IDLE.
- MULH/MULHSU/MULHU with RS1=0x80000000, RS2=0xFFFFFFFF → OUT=0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFFE/2 → 0x7FFFFFFF; READY exactly 33 cycles after capture.
- Divide by zero: DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Overflow: DIV 0x80000000/-1 → 0x80000000, REM → 0. With RV32M_DIV_EARLY_EXIT_EN, READY after 1 cycle.
- Flush: START dropped mid-DIV at iteration 10 → IDLE next cycle, OUT unchanged. A new START then gives a correct result.
- Async reset asserted mid-DIV → immediately IDLE, OUT=0, READY=!START.

Source files
------------

// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared constants and state encoding for the RV32M multiply/divide unit.
package rv32m_pkg;

    localparam int XLEN = 32;

    // funct3 encodings of the M extension
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rv32m_div_core.sv
// rv32m_div_core: unsigned restoring divider, one quotient bit per cycle.
// 'start' loads the operands, 'abort' drops an iteration in flight, 'last' is
// high during the final iteration while quo_nxt/rem_nxt carry the final result.
// A zero divisor naturally yields quotient all-ones and remainder = dividend.
module rv32m_div_core
    import rv32m_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            last,
    output logic [XLEN-1:0] quo_nxt,
    output logic [XLEN-1:0] rem_nxt
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvsr_q;
    logic [4:0]      cnt_q;
    logic            busy_q;
    logic [XLEN:0]   shifted;
    logic            ge;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        ge      = (shifted >= {1'b0, dvsr_q});
        rem_nxt = ge ? (shifted[XLEN-1:0] - dvsr_q) : shifted[XLEN-1:0];
        quo_nxt = {quo_q[XLEN-2:0], ge};
        last    = busy_q && (cnt_q == 5'd0);
    end

    // Iteration registers: load on start, step while busy, stop on abort or last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (abort) begin
            // NOTE: non-blocking assignments keep every register reading pre-edge values.
            busy_q <= 1'b0;
        end else if (start) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvsr_q <= divisor;
            cnt_q  <= 5'd31;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            quo_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rv32m_muldiv.sv
// rv32m_muldiv: RV32M multiply/divide unit for the execute stage.
// Multiplies finish 2 cycles after capture, divides 33 cycles after capture.
// Optional: define RV32M_DIV_EARLY_EXIT_EN to resolve divide-by-zero and signed
// overflow directly at capture (1-cycle latency).
module rv32m_muldiv #(
    parameter int XLEN = rv32m_pkg::XLEN
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic            STALL_M_STD,
    input  logic [2:0]      M_CNT,
    input  logic [XLEN-1:0] RS1,
    input  logic [XLEN-1:0] RS2,
    output logic [XLEN-1:0] OUT,
    output logic            READY
);
    import rv32m_pkg::*;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   op_a_q, op_b_q;
    logic [2:0]        f3_q;
    logic              div_start, div_abort, div_last;
    logic [XLEN-1:0]   div_quo, div_rem;
    logic [XLEN-1:0]   div_mag_a, div_mag_b, div_res;
    logic              q_neg, r_neg;
    logic              mul_a_signed, mul_b_signed;
    logic [2*XLEN-1:0] mul_a_ext, mul_b_ext, mul_prod;
    logic [XLEN-1:0]   mul_res;
    logic              early;
    logic [XLEN-1:0]   early_res;

    // Next-state logic and divider control
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can form.
        state_d   = state_q;
        div_start = 1'b0;
        div_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    if (!M_CNT[2]) begin
                        state_d = ST_MUL;
                    end else if (early) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_DIV;
                        div_start = 1'b1;
                    end
                end
            end
            ST_MUL:  state_d = START ? ST_DONE : ST_IDLE;
            ST_DIV: begin
                if (!START) begin
                    state_d   = ST_IDLE;
                    div_abort = 1'b1;
                end else if (div_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: if (STALL_M_STD || !START) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Multiplier: sign-extend per funct3, the low 64 product bits are exact
    always_comb begin
        mul_a_signed = (f3_q == F3_MULH) || (f3_q == F3_MULHSU);
        mul_b_signed = (f3_q == F3_MULH);
        mul_a_ext    = {{XLEN{mul_a_signed & op_a_q[XLEN-1]}}, op_a_q};
        mul_b_ext    = {{XLEN{mul_b_signed & op_b_q[XLEN-1]}}, op_b_q};
        mul_prod     = mul_a_ext * mul_b_ext;
        mul_res      = (f3_q == F3_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end

    // Operand magnitudes fed to the unsigned divider at capture
    always_comb begin
        div_mag_a = (!M_CNT[0] && RS1[XLEN-1]) ? -RS1 : RS1;
        div_mag_b = (!M_CNT[0] && RS2[XLEN-1]) ? -RS2 : RS2;
    end

    // Sign fixup; a zero divisor keeps the all-ones quotient unsigned-style
    always_comb begin
        q_neg   = !f3_q[0] && (op_a_q[XLEN-1] ^ op_b_q[XLEN-1]) && (op_b_q != '0);
        r_neg   = !f3_q[0] && op_a_q[XLEN-1];
        div_res = f3_q[1] ? (r_neg ? -div_rem : div_rem)
                          : (q_neg ? -div_quo : div_quo);
    end

`ifdef RV32M_DIV_EARLY_EXIT_EN
    // Special-case results resolved straight from the inputs at capture
    always_comb begin
        early     = 1'b0;
        early_res = RS1;
        if (RS2 == '0) begin
            early     = 1'b1;
            early_res = M_CNT[1] ? RS1 : '1;
        end else if (!M_CNT[0] && (RS1 == {1'b1, {(XLEN-1){1'b0}}}) && (RS2 == '1)) begin
            early     = 1'b1;
            early_res = M_CNT[1] ? '0 : RS1;
        end
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // Operand capture and result register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_a_q <= '0;
            op_b_q <= '0;
            f3_q   <= '0;
            OUT    <= '0;
        end else begin
            if (state_q == ST_IDLE && START) begin
                op_a_q <= RS1;
                op_b_q <= RS2;
                f3_q   <= M_CNT;
                if (M_CNT[2] && early) OUT <= early_res;
            end
            if (state_q == ST_MUL && START) OUT <= mul_res;
            if (state_q == ST_DIV && START && div_last) OUT <= div_res;
        end
    end

    assign READY = (state_q == ST_DONE) || (state_q == ST_IDLE && !START);

    rv32m_div_core u_div_core (
        .clk      (CLK),
        .rst_n    (RST_N),
        .start    (div_start),
        .abort    (div_abort),
        .dividend (div_mag_a),
        .divisor  (div_mag_b),
        .last     (div_last),
        .quo_nxt  (div_quo),
        .rem_nxt  (div_rem)
    );

endmodule

// File: tb/tb_rv32m_muldiv.sv
// tb_rv32m_muldiv: directed scoreboard bench for rv32m_muldiv.
module tb_rv32m_muldiv;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

`ifdef RV32M_DIV_EARLY_EXIT_EN
    localparam int LAT_SPECIAL = 1;
`else
    localparam int LAT_SPECIAL = 33;
`endif

    logic        CLK = 1'b0;
    logic        RST_N, START, STALL_M_STD;
    logic [2:0]  M_CNT;
    logic [31:0] RS1, RS2, OUT;
    logic        READY;

    rv32m_muldiv dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .START       (START),
        .STALL_M_STD (STALL_M_STD),
        .M_CNT       (M_CNT),
        .RS1         (RS1),
        .RS2         (RS2),
        .OUT         (OUT),
        .READY       (READY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          id;
        logic [31:0] val;
        int          lat;
        int          start_cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          op_id = 0;
    logic [31:0] last_exp = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: one pop per transaction, on the first cycle the result is presented
    initial begin
        logic hit, prev_hit;
        exp_t e;
        prev_hit = 1'b0;
        forever begin
            @(negedge CLK);
            hit = RST_N && START && READY;
            if (hit && !prev_hit) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got %h, no result was pending", OUT);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("op%0d_out", e.id), OUT, e.val);
                    check($sformatf("op%0d_latency", e.id), cyc - e.start_cyc, e.lat);
                end
            end
            prev_hit = hit;
        end
    end

    // Issue one op at posedge+1; returns at posedge+1 after the result was presented
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit scramble);
        bit   got;
        exp_t d;
        op_id++;
        RS1   = a;
        RS2   = b;
        M_CNT = f3;
        START = 1'b1;
        sb.push_back('{op_id, exp, lat, cyc});
        last_exp = exp;
        @(negedge CLK);
        check($sformatf("op%0d_stall_before_capture", op_id), READY, 1'b0);
        if (scramble) begin
            @(posedge CLK);
            #1;
            RS1   = 32'hDEADBEEF;
            RS2   = 32'h00000003;
            M_CNT = F_MUL;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CLK);
            got = READY;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL op%0d_timeout: READY stayed 0, required within 40 cycles", op_id);
            if (sb.size() > 0) d = sb.pop_front();
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0; START = 1'b0; STALL_M_STD = 1'b1;
        M_CNT = '0; RS1 = '0; RS2 = '0;
        #12;
        check("reset_out", OUT, 32'h0);
        check("reset_ready", READY, 1'b1);
        @(posedge CLK); #1 RST_N = 1'b1;
        @(posedge CLK); #1;

        // MUL held in DONE while the pipeline is stalled, then released
        STALL_M_STD = 1'b0;
        issue(F_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 2, 1'b0);
        repeat (3) begin
            @(negedge CLK);
            check("mul_hold_ready", READY, 1'b1);
            check("mul_hold_out", OUT, 32'hFFFFFFEB);
        end
        @(posedge CLK); #1 STALL_M_STD = 1'b1;
        @(posedge CLK); #1;

        // Back-to-back ops with START held high
        issue(F_MULH,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2, 1'b0);
        issue(F_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2, 1'b0);
        issue(F_MULHU,  32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 2, 1'b0);
        issue(F_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
        issue(F_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
        issue(F_DIVU,   32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, 33, 1'b0);
        issue(F_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, LAT_SPECIAL, 1'b0);
        issue(F_REMU,   32'd5,        32'd0,        32'd5,        LAT_SPECIAL, 1'b0);
        issue(F_DIV,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, LAT_SPECIAL, 1'b0);
        issue(F_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, LAT_SPECIAL, 1'b0);
        issue(F_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_SPECIAL, 1'b0);
        issue(F_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_SPECIAL, 1'b0);
        issue(F_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33, 1'b0);
        issue(F_REMU,   32'd100,      32'd7,        32'd2,        33, 1'b0);
        issue(F_DIVU,   32'd100,      32'd7,        32'd14,       33, 1'b0);

        // Flush: START dropped after ten divide iterations
        RS1 = 32'd1000; RS2 = 32'd7; M_CNT = F_DIV;
        @(posedge CLK);
        repeat (10) @(posedge CLK);
        #1 START = 1'b0;
        @(negedge CLK);
        check("flush_still_busy", READY, 1'b0);
        @(posedge CLK); #1;
        check("flush_idle_ready", READY, 1'b1);
        check("flush_out_kept", OUT, last_exp);

        // Fresh op after the flush, with operands changed after capture
        issue(F_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33, 1'b1);

        // Asynchronous reset in the middle of a divide
        RS1 = 32'd1000; RS2 = 32'd3; M_CNT = F_DIVU; START = 1'b1;
        repeat (6) @(posedge CLK);
        #1 RST_N = 1'b0;
        #1;
        check("rst_mid_div_out", OUT, 32'h0);
        check("rst_mid_div_ready_start_high", READY, 1'b0);
        START = 1'b0;
        #1;
        check("rst_mid_div_ready_start_low", READY, 1'b1);
        @(posedge CLK); #1 RST_N = 1'b1;
        @(posedge CLK); #1;
        issue(F_MUL, 32'h12345678, 32'h00000010, 32'h23456780, 2, 1'b0);

        START = 1'b0;
        repeat (3) @(posedge CLK);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
